// File: rtl/rxshift.sv
// USRT receive shifter: samples one line bit per bit clock, assembles start/data/stop frames
// and queues complete words in a first-word-fall-through FIFO with framing/overrun flags.
module rxshift #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_Bclk,
  input  logic                          i_Reset,
  input  logic                          i_Rx_Serial,
  input  logic                          i_Rx_Read,
  input  logic                          i_Err_Clear,
  output logic [DATA_BITS-1:0]          o_Rx_Data,
  output logic                          o_Rx_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_Rx_Count,
  output logic                          o_Busy,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
  output logic [1:0]                    o_State
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_STOP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 frame_err;
  logic                 overrun;

  logic push_req, full, do_pop, do_push, set_ov, set_fe;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    push_req = (state == S_STOP) && i_Rx_Serial;
    set_fe   = (state == S_STOP) && !i_Rx_Serial;
    full     = (count == CNT_W'(FIFO_DEPTH));
    do_pop   = i_Rx_Read && (count != '0);
    do_push  = push_req && (!full || do_pop);
    set_ov   = push_req && full && !do_pop;
  end

  always_ff @(posedge i_Bclk) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      shift_reg <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_Rx_Serial) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: begin
          shift_reg[idx] <= i_Rx_Serial;
          if (idx == IDX_W'(DATA_BITS - 1)) state <= S_STOP;
          else                              idx   <= idx + IDX_W'(1);
        end
        S_STOP: begin
          state <= i_Rx_Serial ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (i_Rx_Serial) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Set has priority over a simultaneous clear.
      frame_err <= (frame_err && !i_Err_Clear) || set_fe;
      overrun   <= (overrun && !i_Err_Clear) || set_ov;
    end
  end

  always_ff @(posedge i_Bclk) begin
    if (do_push && !i_Reset) mem[wr_ptr] <= shift_reg;
  end

  always_comb begin
    o_Rx_Valid  = (count != '0);
    o_Rx_Data   = o_Rx_Valid ? mem[rd_ptr] : '0;
    o_Rx_Count  = count;
    o_Busy      = (state != S_IDLE);
    o_Frame_Err = frame_err;
    o_Overrun   = overrun;
    o_State     = state;
  end

endmodule

// File: tb/tb_rxshift.sv
// Directed bench for rxshift: hand-computed frames on the serial line, head/count/flag checks.
module tb_rxshift;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr;
  logic [7:0] data;
  logic       valid;
  logic [2:0] cnt;
  logic       busy;
  logic       ferr;
  logic       ovr;
  logic [1:0] st;

  int n_vec  = 0;
  int n_miss = 0;

  rxshift #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_Bclk      (clk),
    .i_Reset     (rst),
    .i_Rx_Serial (rx),
    .i_Rx_Read   (rd),
    .i_Err_Clear (clr),
    .o_Rx_Data   (data),
    .o_Rx_Valid  (valid),
    .o_Rx_Count  (cnt),
    .o_Busy      (busy),
    .o_Frame_Err (ferr),
    .o_Overrun   (ovr),
    .o_State     (st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic b);
    rx = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) line(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic rd_on_stop, input logic clr_on_stop);
    line(1'b0);
    for (int i = 0; i < 8; i++) line(d[i]);
    rd  = rd_on_stop;
    clr = clr_on_stop;
    line(stop_bit);
    rd  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic clear_errs();
    clr = 1'b1;
    rx  = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
    tick(); tick();
    chk("rst_data",  data,  8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_count", cnt,   3'd0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_ferr",  ferr,  1'b0);
    chk("rst_ovr",   ovr,   1'b0);
    rst = 1'b0;
    idle(2);

    // Pop on an empty FIFO does nothing.
    pop();
    chk("empty_pop_count", cnt, 3'd0);

    // Single frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5_data",  data,  8'hA5);
    chk("a5_valid", valid, 1'b1);
    chk("a5_count", cnt,   3'd1);
    chk("a5_busy",  busy,  1'b0);
    pop();
    chk("a5_pop_valid", valid, 1'b0);

    // Three frames with one idle cycle between.
    exp_q = '{8'h01, 8'h80, 8'hFF};
    send_frame(8'h01, 1'b1, 1'b0, 1'b0); idle(1);
    send_frame(8'h80, 1'b1, 1'b0, 1'b0); idle(1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0); idle(1);
    chk("three_count", cnt, 3'd3);
    while (exp_q.size() > 0) begin
      chk("three_head", data, exp_q.pop_front());
      pop();
    end
    chk("three_empty_count", cnt,   3'd0);
    chk("three_empty_valid", valid, 1'b0);

    // Bad stop bit, line held low: framing error, no push, no false start.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("brk_ferr",  ferr, 1'b1);
    chk("brk_count", cnt,  3'd0);
    chk("brk_state", st,   2'd3);
    for (int i = 0; i < 5; i++) line(1'b0);
    chk("brk_held_state", st,  2'd3);
    chk("brk_held_count", cnt, 3'd0);
    line(1'b1);
    chk("brk_release_busy", busy, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("after_brk_data",  data, 8'h11);
    chk("after_brk_count", cnt,  3'd1);
    clear_errs();
    chk("ferr_cleared", ferr, 1'b0);
    pop();

    // Clear in the same cycle as a new framing error: set wins.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("ferr_set_wins", ferr, 1'b1);
    idle(2);
    clear_errs();
    chk("ferr_cleared2", ferr, 1'b0);

    // Five frames into a 4-deep FIFO: last one dropped.
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    chk("ovr_flag",  ovr,  1'b1);
    chk("ovr_count", cnt,  3'd4);
    chk("ovr_head",  data, 8'h10);
    clear_errs();
    chk("ovr_cleared", ovr, 1'b0);

    // Full FIFO, pop on the stop-bit cycle: both happen, no overrun.
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    chk("fullpop_count", cnt,  3'd4);
    chk("fullpop_ovr",   ovr,  1'b0);
    chk("fullpop_head",  data, 8'h11);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h55};
    idle(1);
    while (exp_q.size() > 0) begin
      chk("fullpop_drain", data, exp_q.pop_front());
      pop();
    end
    chk("fullpop_empty", valid, 1'b0);

    // Reset at data bit 4 with a word already queued.
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(1);
    line(1'b0);
    for (int i = 0; i < 4; i++) line(1'b1);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    line(1'b0);
    chk("mrst_data",  data,  8'h00);
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_count", cnt,   3'd0);
    chk("mrst_busy",  busy,  1'b0);
    rst = 1'b0;
    idle(3);
    chk("mrst_idle_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    chk("after_rst_data",  data, 8'h7E);
    chk("after_rst_count", cnt,  3'd1);
    chk("after_rst_ferr",  ferr, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
